pm_digital_config_shifter: RTL and testbench
============================================

Name: pm_digital_config_shifter

Overview:
- Consumer (slave) end of the soc_pm_digital_config interface, placed at the pixel-matrix boundary.
- Watches the 32-bit word {res, th} driven by the SoC-side config register.
- On any change, or on request, serialises the word MSB-first into the pixel-matrix configuration shift chain, then issues a latch pulse.
- Gives the matrix a glitch-free, atomically updated copy of the SoC digital config.

Parameters:
- CLK_DIV, 2, half-period of pm_sclk in clk cycles; legal range 1..255.
- WORD_W, 32, serial word width; fixed to 32 (24 res + 8 th), elaborated only as a constant.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- digital_config  interface  soc_pm_digital_config.slave  res[23:0] and th[7:0] from SoC
- force_update  input  1  single-cycle request to resend the current word even if unchanged
- busy  output  1  high while a transfer is in progress (SHIFT or LATCH)
- done  output  1  one-cycle pulse on the clk after the latch pulse ends
- pm_sclk  output  1  serial clock to matrix
- pm_sdata  output  1  serial data to matrix
- pm_latch  output  1  latch strobe to matrix

Behaviour:
- Single clock clk. Reset is synchronous, active-high on rst.
- Reset values:
  - busy, done, pm_sclk, pm_sdata, pm_latch = 0.
  - shadow = 0.
  - pending = 1, so one transfer starts automatically after reset.
- word = {res, th}; bit 31 = res[23], bit 0 = th[0].
- States:
  - IDLE:
    - If pending, force_update, or word != shadow: capture shadow <= word, clear pending, go to SHIFT with bit_cnt = 31 and div_cnt = 0.
    - Entry decision takes 1 cycle. The first SHIFT cycle follows on the next clk.
  - SHIFT:
    - pm_sdata = shadow[bit_cnt]. It is stable for the whole bit.
    - pm_sclk is low for CLK_DIV cycles, then high for CLK_DIV cycles. The matrix samples on the rising edge.
    - After the high phase, bit_cnt decrements. After bit 0's high phase, go to LATCH.
    - One bit takes 2*CLK_DIV cycles; the whole word takes 64*CLK_DIV cycles.
  - LATCH:
    - pm_sclk = 0, pm_sdata = 0, pm_latch = 1 for CLK_DIV cycles.
    - Then go to IDLE and pulse done for 1 cycle.
- busy = 1 in SHIFT and LATCH.
- Total latency from the change to the done pulse = 1 + 64*CLK_DIV + CLK_DIV + 1 cycles (132 at CLK_DIV=2).
- Changes to word during SHIFT/LATCH do not disturb the transfer, because only shadow is shifted. They are detected by the compare in IDLE on return, which starts a new transfer.
- force_update during busy is remembered in pending and serviced at the next IDLE. Multiple requests collapse into one.
- Simultaneous word change and force_update in IDLE: one transfer only.
- rst mid-transfer: all outputs return to 0 at once, no latch is issued, and pending is set, so a full resend follows.
- div_cnt is a $clog2(CLK_DIV+1)-bit counter and bit_cnt is 5 bits; neither wraps past its terminal value.

Optional Feature:
- Macro PM_CONFIG_READBACK_EN.
- When defined, the block adds:
  - input pm_sret (the chain's serial output);
  - output readback[31:0];
  - output readback_err.
- pm_sret is sampled on each pm_sclk rising-edge cycle and shifted into a register. At LATCH entry, that register is copied to readback.
- readback_err is 1 if readback differs from the word sent on the previous transfer.
- readback_err is sticky until the next done pulse. Reset value 0.
- When the macro is not defined, these ports and their logic do not exist.

Decomposition:
- Package pm_config_pkg:
  - PM_CFG_WORD_W = 32;
  - typedef pm_cfg_word_t as logic [31:0];
  - enum pm_shift_state_t {IDLE, SHIFT, LATCH}.
- Optional sub-module pm_sclk_divider: div_cnt, phase toggle, and bit_end/phase_end strobes, parameterised by CLK_DIV.

Test Plan:
- Release reset with res=0, th=0, CLK_DIV=2 -> transfer starts automatically, 32 rising edges of pm_sclk with pm_sdata all 0, pm_latch high for 2 cycles, done at cycle 132.
- Idle, then set th=8'hA5, res=24'h000001 -> serial stream 0x000001A5 MSB-first. A chain model captures 0x000001A5 at pm_latch.
- During bit 10 of a transfer, change th to 8'h3C -> the current transfer completes with the old word. A second transfer with the new th starts 1 cycle after done.
- Idle with word unchanged, pulse force_update twice during one busy period -> exactly one extra transfer.
- Assert rst at bit 16 -> outputs 0 next cycle, no pm_latch. A full transfer follows reset release.
- With PM_CONFIG_READBACK_EN and pm_sret as a 32-bit loopback delayed by one word, send 0x12345678 then 0x12345678 -> readback_err = 0. Flip one pm_sret bit -> readback_err = 1 after LATCH.

Source files
------------

// File: rtl/pm_config_pkg.sv
// Shared types for the pixel-matrix digital config shifter.
// Word layout is {res[23:0], th[7:0]}, bit 31 shifted first.
package pm_config_pkg;

  localparam int PM_CFG_WORD_W = 32;

  typedef logic [PM_CFG_WORD_W-1:0] pm_cfg_word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } pm_shift_state_t;

endpackage

// File: rtl/soc_pm_digital_config.sv
// SoC digital config bundle: pixel resolution and threshold fields.
// The SoC register drives master; the matrix-side shifter is slave.
interface soc_pm_digital_config;

  logic [23:0] res;
  logic [7:0]  th;

  modport master (output res, output th);
  modport slave  (input res, input th);

endinterface

// File: rtl/pm_sclk_divider.sv
// Serial clock divider: CLK_DIV cycles per phase, low phase first.
// phase_end closes a phase; bit_end closes the high phase of a bit.
module pm_sclk_divider #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic phase_nxt,
  output logic phase_end,
  output logic bit_end
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_nxt;
  logic          phase;

  assign phase_end = run && (div_cnt == DIV_LAST);
  assign bit_end   = phase_end && phase;

  always_comb begin
    div_nxt   = div_cnt;
    phase_nxt = phase;
    if (clear) begin
      div_nxt   = '0;
      phase_nxt = 1'b0;
    end else if (phase_end) begin
      div_nxt   = '0;
      phase_nxt = ~phase;
    end else if (run) begin
      div_nxt = div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      phase   <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      phase   <= phase_nxt;
    end
  end

endmodule

// File: rtl/pm_digital_config_shifter.sv
// Shifts the SoC config word into the pixel-matrix chain, then latches it.
// Define PM_CONFIG_READBACK_EN to add chain readback and mismatch flag.
module pm_digital_config_shifter
  import pm_config_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int WORD_W  = PM_CFG_WORD_W
) (
  input  logic                       clk,
  input  logic                       rst,
  soc_pm_digital_config.slave        digital_config,
  input  logic                       force_update,
  output logic                       busy,
  output logic                       done,
  output logic                       pm_sclk,
  output logic                       pm_sdata,
  output logic                       pm_latch
`ifdef PM_CONFIG_READBACK_EN
  ,
  input  logic                       pm_sret,
  output pm_cfg_word_t               readback,
  output logic                       readback_err
`endif
);

  localparam logic [4:0] TOP_BIT = 5'(WORD_W - 1);

  pm_shift_state_t state;
  pm_shift_state_t state_n;
  pm_cfg_word_t    word;
  pm_cfg_word_t    shadow;
  pm_cfg_word_t    shadow_n;
  logic [4:0]      bit_cnt;
  logic [4:0]      bit_n;
  logic            pending;
  logic            pending_n;
  logic            done_n;
  logic            run;
  logic            clear;
  logic            phase_nxt;
  logic            phase_end;
  logic            bit_end;

  assign word  = {digital_config.res, digital_config.th};
  assign run   = (state != IDLE);
  assign clear = (state_n != state);

  pm_sclk_divider #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .run       (run),
    .phase_nxt (phase_nxt),
    .phase_end (phase_end),
    .bit_end   (bit_end)
  );

  always_comb begin
    state_n   = state;
    shadow_n  = shadow;
    bit_n     = bit_cnt;
    pending_n = pending | force_update;
    done_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (pending || force_update || (word != shadow)) begin
          shadow_n  = word;
          pending_n = 1'b0;
          bit_n     = TOP_BIT;
          state_n   = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_end) begin
          if (bit_cnt == 5'd0) state_n = LATCH;
          else bit_n = bit_cnt - 5'd1;
        end
      end
      LATCH: begin
        if (phase_end) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs come straight from flops, decoded from next-state values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      shadow   <= '0;
      bit_cnt  <= '0;
      pending  <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      pm_sclk  <= 1'b0;
      pm_sdata <= 1'b0;
      pm_latch <= 1'b0;
    end else begin
      state    <= state_n;
      shadow   <= shadow_n;
      bit_cnt  <= bit_n;
      pending  <= pending_n;
      busy     <= (state_n != IDLE);
      done     <= done_n;
      pm_sclk  <= (state_n == SHIFT) && phase_nxt;
      pm_sdata <= (state_n == SHIFT) && shadow_n[bit_n];
      pm_latch <= (state_n == LATCH);
    end
  end

`ifdef PM_CONFIG_READBACK_EN
  pm_cfg_word_t sreg;
  pm_cfg_word_t last_sent;
  logic         mism_q;
  logic         sclk_rise;
  logic         latch_entry;
  logic         mism;

  assign sclk_rise   = (state_n == SHIFT) && phase_nxt && !pm_sclk;
  assign latch_entry = (state == SHIFT) && (state_n == LATCH);
  assign mism        = (sreg != last_sent);

  // Error raises at latch entry and holds until the next transfer's done.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg         <= '0;
      last_sent    <= '0;
      readback     <= '0;
      readback_err <= 1'b0;
      mism_q       <= 1'b0;
    end else begin
      if (sclk_rise) sreg <= {sreg[WORD_W-2:0], pm_sret};
      if (latch_entry) begin
        readback  <= sreg;
        last_sent <= shadow;
        mism_q    <= mism;
        if (mism) readback_err <= 1'b1;
      end
      if (done_n) readback_err <= mism_q;
    end
  end
`endif

endmodule

// File: tb/tb_pm_digital_config_shifter.sv
// Bench for pm_digital_config_shifter: vector table, corner sequences,
// random word changes checked against a serial-chain model.
module tb_pm_digital_config_shifter;

  localparam int CLK_DIV = 2;
  localparam int LAT     = 1 + 64 * CLK_DIV + CLK_DIV + 1;

  logic clk = 1'b0;
  logic rst;
  logic force_update;
  logic busy, done, pm_sclk, pm_sdata, pm_latch;

  int checks = 0;
  int errors = 0;

  soc_pm_digital_config cfg ();

`ifdef PM_CONFIG_READBACK_EN
  logic        pm_sret;
  logic [31:0] readback;
  logic        readback_err;
  logic [31:0] lb_chain = '0;
  logic        flip = 1'b0;
  always @(posedge pm_sclk) lb_chain <= {lb_chain[30:0], pm_sdata};
  assign pm_sret = lb_chain[31] ^ flip;
`endif

  pm_digital_config_shifter #(
    .CLK_DIV (CLK_DIV)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .digital_config (cfg),
    .force_update   (force_update),
    .busy           (busy),
    .done           (done),
    .pm_sclk        (pm_sclk),
    .pm_sdata       (pm_sdata),
    .pm_latch       (pm_latch)
`ifdef PM_CONFIG_READBACK_EN
    ,
    .pm_sret        (pm_sret),
    .readback       (readback),
    .readback_err   (readback_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Matrix chain model: samples sdata on each sclk rise, captures at latch.
  logic [31:0] chain = '0;
  logic [31:0] got[$];
  int   rises = 0;
  int   latch_w = 0;
  logic sclk_q = 1'b0, latch_q = 1'b0, done_q = 1'b0, sd_hold = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      rises   = 0;
      latch_w = 0;
    end else begin
      if (pm_sclk && !sclk_q) begin
        chain   = {chain[30:0], pm_sdata};
        sd_hold = pm_sdata;
        rises++;
      end else if (pm_sclk) begin
        chk("sdata_stable", pm_sdata, sd_hold);
      end
      if (pm_latch) begin
        latch_w++;
        chk("latch_quiet", {pm_sclk, pm_sdata}, 2'b00);
      end
      if (pm_latch && !latch_q) begin
        chk("bits_per_word", rises, 32);
        got.push_back(chain);
        rises = 0;
      end
      if (!pm_latch && latch_q) begin
        chk("latch_width", latch_w, CLK_DIV);
        latch_w = 0;
      end
      if (done) chk("done_pulse", done_q, 0);
    end
    sclk_q  = pm_sclk;
    latch_q = pm_latch;
    done_q  = done;
  end

  task automatic wait_done(output int cyc);
    cyc = 1;
    do begin
      @(negedge clk);
      force_update = 1'b0;
      cyc++;
    end while (!done && cyc < 2000);
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic wait_rises(input int n);
    int g = 0;
    while (rises != n && g < 2000) begin
      @(negedge clk);
      force_update = 1'b0;
      g++;
    end
    if (rises != n) chk("rise_timeout", rises, n);
  endtask

  task automatic set_word(input logic [31:0] w);
    cfg.res = w[31:8];
    cfg.th  = w[7:0];
  endtask

  typedef struct {
    logic [31:0] word;
    bit          frc;
    bit          xfer;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int cyc, n0, q, g;
    logic [31:0] w, old_w, new_w;
    logic [31:0] applied[$];
    bit found;

    vecs[0] = '{32'h0000_01A5, 1'b0, 1'b1, 32'h0000_01A5};
    vecs[1] = '{32'hFFFF_FFFF, 1'b0, 1'b1, 32'hFFFF_FFFF};
    vecs[2] = '{32'hFFFF_FFFF, 1'b0, 1'b0, 32'hFFFF_FFFF};
    vecs[3] = '{32'hFFFF_FFFF, 1'b1, 1'b1, 32'hFFFF_FFFF};
    vecs[4] = '{32'h1234_5678, 1'b1, 1'b1, 32'h1234_5678};
    vecs[5] = '{32'h1234_5678, 1'b0, 1'b0, 32'h1234_5678};

    rst = 1'b1;
    force_update = 1'b0;
    set_word(32'h0);
    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy, done, pm_sclk, pm_sdata, pm_latch}, 0);

    // Auto transfer after reset release
    n0 = got.size();
    rst = 1'b0;
    wait_done(cyc);
    chk("reset_latency", cyc, LAT);
    chk("reset_count", got.size() - n0, 1);
    chk("reset_word", got[got.size()-1], 32'h0);

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      set_word(vecs[i].word);
      force_update = vecs[i].frc;
      n0 = got.size();
      if (vecs[i].xfer) begin
        wait_done(cyc);
        chk($sformatf("vec%0d_latency", i), cyc, LAT);
        chk($sformatf("vec%0d_count", i), got.size() - n0, 1);
        chk($sformatf("vec%0d_word", i), got[got.size()-1], vecs[i].exp);
      end else begin
        repeat (150) @(negedge clk);
        chk($sformatf("vec%0d_no_xfer", i), got.size() - n0, 0);
      end
    end

    // Word change during bit 10 finishes old word, then resends
    old_w = 32'hABCD_EF11;
    new_w = 32'hABCD_EF3C;
    @(negedge clk);
    set_word(old_w);
    wait_rises(22);
    cfg.th = 8'h3C;
    wait_done(cyc);
    chk("mid_old_word", got[got.size()-1], old_w);
    chk("mid_idle_at_done", busy, 0);
    @(negedge clk);
    chk("mid_restart", busy, 1);
    wait_done(cyc);
    chk("mid_new_word", got[got.size()-1], new_w);

    // Two force pulses during one busy period -> one extra transfer
    @(negedge clk);
    n0 = got.size();
    force_update = 1'b1;
    @(negedge clk);
    force_update = 1'b0;
    wait_rises(4);
    force_update = 1'b1;
    @(negedge clk);
    force_update = 1'b0;
    repeat (10) @(negedge clk);
    force_update = 1'b1;
    wait_done(cyc);
    wait_done(cyc);
    repeat (150) @(negedge clk);
    chk("force_collapse", got.size() - n0, 2);
    chk("force_word", got[got.size()-1], new_w);

    // Reset at bit 16 aborts without latch, then full resend
    @(negedge clk);
    force_update = 1'b1;
    @(negedge clk);
    force_update = 1'b0;
    wait_rises(16);
    n0 = got.size();
    rst = 1'b1;
    @(negedge clk);
    chk("abort_outputs", {busy, done, pm_sclk, pm_sdata, pm_latch}, 0);
    @(negedge clk);
    rst = 1'b0;
    wait_done(cyc);
    chk("abort_latency", cyc, LAT);
    chk("abort_count", got.size() - n0, 1);
    chk("abort_word", got[got.size()-1], new_w);

`ifdef PM_CONFIG_READBACK_EN
    @(negedge clk);
    set_word(32'h1234_5678);
    wait_done(cyc);
    @(negedge clk);
    force_update = 1'b1;
    wait_done(cyc);
    chk("rb_word", readback, 32'h1234_5678);
    chk("rb_err_clear", readback_err, 0);
    @(negedge clk);
    force_update = 1'b1;
    wait_rises(5);
    flip = 1'b1;
    wait_rises(6);
    flip = 1'b0;
    wait_done(cyc);
    chk("rb_flip_word", readback, 32'h1234_5678 ^ (32'h1 << 26));
    chk("rb_err_set", readback_err, 1);
`endif

    // Random word changes, some landing mid-transfer
    n0 = got.size();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      w = $urandom;
      set_word(w);
      applied.push_back(w);
      repeat ($urandom_range(0, 200)) @(negedge clk);
    end
    q = 0;
    g = 0;
    while (q < 4 && g < 2000) begin
      @(negedge clk);
      if (busy) q = 0;
      else q++;
      g++;
    end
    chk("rand_settle", q >= 4, 1);
    chk("rand_any", got.size() > n0, 1);
    chk("rand_final", got[got.size()-1], applied[applied.size()-1]);
    for (int k = n0; k < got.size(); k++) begin
      found = 1'b0;
      foreach (applied[j]) if (applied[j] == got[k]) found = 1'b1;
      chk($sformatf("rand_member%0d", k), found, 1);
      chk($sformatf("rand_changed%0d", k), got[k] != got[k-1], 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
